// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG encoder front end.
// Default geometry is an 8x8 block of 8-bit {Cr,Cb,Y} components.
package jpeg_enc_pkg;

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_BLK_LOG2 = 6;
    localparam int BLK_SAMPLES  = 1 << DEF_BLK_LOG2;

    typedef struct packed {
        logic [DEF_PIX_W-1:0] cr;
        logic [DEF_PIX_W-1:0] cb;
        logic [DEF_PIX_W-1:0] y;
    } ycc_pix_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Unsigned c -> two's-complement (c - 2**(W-1)) is just an MSB flip.
    function automatic logic [DEF_PIX_W-1:0] level_shift(input logic [DEF_PIX_W-1:0] c);
        return {~c[DEF_PIX_W-1], c[DEF_PIX_W-2:0]};
    endfunction

endpackage

// File: rtl/ycbcr_block_buffer_if.sv
// Pixel-in / block-out stream bundle of the YCbCr block buffer.
// master = producer/consumer side (testbench), slave = the buffer.
interface ycbcr_block_buffer_if
    import jpeg_enc_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
);
    logic                     enable;
    logic [3*PIX_W-1:0]       data_in;
    logic signed [PIX_W-1:0]  y_out;
    logic signed [PIX_W-1:0]  cb_out;
    logic signed [PIX_W-1:0]  cr_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_first;
    logic                     out_last;
    logic                     overflow;

    modport master (
        output enable, data_in, out_ready,
        input  y_out, cb_out, cr_out, out_valid, out_first, out_last, overflow
    );

    modport slave (
        input  enable, data_in, out_ready,
        output y_out, cb_out, cr_out, out_valid, out_first, out_last, overflow
    );
endinterface

// File: rtl/ycc_pingpong_ram.sv
// Two-bank block storage: one synchronous write port, one combinational read port.
// The address MSB selects the bank.
module ycc_pingpong_ram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // NOTE: storage is deliberately not reset; the full flags gate every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ycbcr_block_buffer.sv
// Ping-pong 8x8 block buffer between the RGB->YCbCr converter and the DCT stages.
// Define YCC_BLK_TRANSPOSE_EN to replay each block column-major instead of raster order.
module ycbcr_block_buffer
    import jpeg_enc_pkg::*;
#(
    parameter int PIX_W    = DEF_PIX_W,
    parameter int BLK_LOG2 = DEF_BLK_LOG2
) (
    input logic                 clk,
    input logic                 rst,
    ycbcr_block_buffer_if.slave bus
);

    localparam int DATA_W = 3 * PIX_W;
    localparam int ADDR_W = BLK_LOG2 + 1;

    // Write side
    logic                wr_bank_q, wr_bank_d;
    logic [BLK_LOG2-1:0] wr_cnt_q, wr_cnt_d;
    logic                wr_en;
    logic [1:0]          full_q, full_d, full_set, full_clr;
    logic                ovf_q, ovf_d;

    // Read side
    rd_state_e           state_q, state_d;
    logic                rd_bank_q, rd_bank_d;
    logic [BLK_LOG2-1:0] rd_cnt_q, rd_cnt_d;
    logic                load;
    logic                sel_bank;
    logic [BLK_LOG2-1:0] sel_cnt, sel_idx;
    logic [DATA_W-1:0]   rd_data;
    ycc_pix_t            rd_pix;

    // Output register
    logic [PIX_W-1:0]    y_q, y_d, cb_q, cb_d, cr_q, cr_d;
    logic                valid_q, valid_d, first_q, first_d, last_q, last_d;

    assign wr_en = bus.enable && !full_q[wr_bank_q];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        full_set  = '0;
        ovf_d     = ovf_q;
        if (bus.enable) begin
            if (full_q[wr_bank_q]) begin
                ovf_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == '1) begin
                    full_set[wr_bank_q] = 1'b1;
                    wr_bank_d           = ~wr_bank_q;
                end
            end
        end
    end

    // Emission index -> storage index; indices 0 and last are fixed points of the swap.
`ifdef YCC_BLK_TRANSPOSE_EN
    localparam int HALF = BLK_LOG2 / 2;
    assign sel_idx = {sel_cnt[HALF-1:0], sel_cnt[BLK_LOG2-1:HALF]};
`else
    assign sel_idx = sel_cnt;
`endif

    ycc_pingpong_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i ({wr_bank_q, wr_cnt_q}),
        .wdata_i (bus.data_in),
        .raddr_i ({sel_bank, sel_idx}),
        .rdata_o (rd_data)
    );

    assign rd_pix = ycc_pix_t'(rd_data);

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        full_clr  = '0;
        load      = 1'b0;
        sel_bank  = rd_bank_q;
        sel_cnt   = rd_cnt_q;
        valid_d   = valid_q;
        first_d   = first_q;
        last_d    = last_q;

        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load    = 1'b1;
                    sel_cnt = '0;
                    state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (valid_q && bus.out_ready) begin
                    if (last_q) begin
                        full_clr[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        // Chain straight into the other bank when it is ready: no bubble.
                        if (full_q[~rd_bank_q]) begin
                            load     = 1'b1;
                            sel_bank = ~rd_bank_q;
                            sel_cnt  = '0;
                        end else begin
                            valid_d = 1'b0;
                            first_d = 1'b0;
                            last_d  = 1'b0;
                            state_d = RD_IDLE;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        if (load) begin
            rd_cnt_d = sel_cnt + 1'b1;
            valid_d  = 1'b1;
            first_d  = (sel_cnt == '0);
            last_d   = (sel_cnt == '1);
        end

        y_d  = load ? level_shift(rd_pix.y)  : y_q;
        cb_d = load ? level_shift(rd_pix.cb) : cb_q;
        cr_d = load ? level_shift(rd_pix.cr) : cr_q;
    end

    assign full_d = (full_q & ~full_clr) | full_set;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
            state_q   <= RD_IDLE;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            y_q       <= '0;
            cb_q      <= '0;
            cr_q      <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            y_q       <= y_d;
            cb_q      <= cb_d;
            cr_q      <= cr_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    assign bus.y_out     = y_q;
    assign bus.cb_out    = cb_q;
    assign bus.cr_out    = cr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Scoreboard bench for ycbcr_block_buffer: a block-level model predicts emitted samples and drops.
// Honours YCC_BLK_TRANSPOSE_EN for the expected emission order.
module tb_ycbcr_block_buffer;
    import jpeg_enc_pkg::*;

    localparam int SIDE = 8;

    typedef struct {
        int y;
        int cb;
        int cr;
        bit first;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ycbcr_block_buffer_if #(.PIX_W(8)) bus ();

    ycbcr_block_buffer #(
        .PIX_W    (8),
        .BLK_LOG2 (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   part[$];
    int   n_full   = 0;
    bit   exp_ovf  = 1'b0;
    int   hs_count = 0;
    bit   armed    = 1'b0;
    bit   stall_prev = 1'b0;
    logic [25:0] snap;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // A finished block is queued in emission order: raster, or column-major when transposed.
    function automatic void push_block();
        exp_t e;
        int   src;
        int   pix;
        for (int k = 0; k < BLK_SAMPLES; k++) begin
`ifdef YCC_BLK_TRANSPOSE_EN
            src = (k % SIDE) * SIDE + (k / SIDE);
`else
            src = k;
`endif
            pix     = part[src];
            e.y     = (pix & 255) - 128;
            e.cb    = ((pix >> 8) & 255) - 128;
            e.cr    = ((pix >> 16) & 255) - 128;
            e.first = (k == 0);
            e.last  = (k == BLK_SAMPLES - 1);
            exp_q.push_back(e);
        end
        part.delete();
    endfunction

    function automatic logic [25:0] out_word();
        return {bus.y_out, bus.cb_out, bus.cr_out, bus.out_first, bus.out_last};
    endfunction

    // Model + monitor: inputs are stable at negedge, so decide what the next edge will do.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            check("overflow", int'(bus.overflow), int'(exp_ovf));
            if (stall_prev) begin
                check("stall_valid", int'(bus.out_valid), 1);
                check("stall_hold", int'(out_word()), int'(snap));
            end
            stall_prev = 1'b0;
            if (rst) begin
                exp_q.delete();
                part.delete();
                n_full  = 0;
                exp_ovf = 1'b0;
            end else begin
                // The input sees the bank state before any release at the same edge.
                if (bus.enable) begin
                    if (n_full == 2) begin
                        exp_ovf = 1'b1;
                    end else begin
                        part.push_back(int'(bus.data_in));
                        if (part.size() == BLK_SAMPLES) begin
                            push_block();
                            n_full++;
                        end
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("y_out",     int'(bus.y_out),     e.y);
                        check("cb_out",    int'(bus.cb_out),    e.cb);
                        check("cr_out",    int'(bus.cr_out),    e.cr);
                        check("out_first", int'(bus.out_first), int'(e.first));
                        check("out_last",  int'(bus.out_last),  int'(e.last));
                        if (e.last) n_full--;
                    end
                end else if (bus.out_valid) begin
                    stall_prev = 1'b1;
                    snap       = out_word();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d);
        bus.enable  = 1'b1;
        bus.data_in = d;
        tick();
        bus.enable  = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && w < 3000) begin
            tick();
            w++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h0;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_y",        int'(bus.y_out),     0);
        check("rst_cb",       int'(bus.cb_out),    0);
        check("rst_cr",       int'(bus.cr_out),    0);
        check("rst_valid",    int'(bus.out_valid), 0);
        check("rst_first",    int'(bus.out_first), 0);
        check("rst_last",     int'(bus.out_last),  0);
        check("rst_overflow", int'(bus.overflow),  0);
        armed = 1'b1;
        rst   = 1'b0;
        tick();

        // Ramp block: first valid exactly one clock after the 64th enable.
        bus.out_ready = 1'b1;
        for (int i = 0; i < BLK_SAMPLES; i++) begin
            send({8'd128, 8'(255 - i), 8'(i)});
        end
        check("latency_before", int'(bus.out_valid), 0);
        tick();
        check("latency_valid", int'(bus.out_valid), 1);
        check("latency_first", int'(bus.out_first), 1);
        h0 = hs_count;
        drain("ramp");
        check("ramp_count", hs_count - h0, BLK_SAMPLES);

        // Two back-to-back blocks stream with no bubble.
        fork
            begin
                for (int i = 0; i < 2 * BLK_SAMPLES; i++) send(24'($urandom));
            end
            begin
                int w   = 0;
                int run = 0;
                while (!bus.out_valid && w < 300) begin
                    tick();
                    w++;
                end
                while (bus.out_valid && run < 300) begin
                    run++;
                    tick();
                end
                check("no_bubble_run", run, 2 * BLK_SAMPLES);
            end
        join
        drain("burst");

        // Both banks full while stalled; one extra sample is dropped.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2 * BLK_SAMPLES; i++) send(24'($urandom));
        check("full_no_ovf", int'(bus.overflow), 0);
        send(24'h5a5a5a);
        check("drop_ovf", int'(bus.overflow), 1);
        repeat (5) tick();
        h0 = hs_count;
        bus.out_ready = 1'b1;
        drain("stall");
        check("stall_count", hs_count - h0, 2 * BLK_SAMPLES);

        // Random producer gaps and random consumer backpressure.
        fork
            begin
                int sent = 0;
                while (sent < 2 * BLK_SAMPLES) begin
                    if ($urandom_range(0, 9) < 4) begin
                        send(24'($urandom));
                        sent++;
                    end else begin
                        tick();
                    end
                end
            end
            begin
                repeat (400) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("random");

        // Reset with one full stalled block plus 40 samples of the next.
        bus.out_ready = 1'b0;
        for (int i = 0; i < BLK_SAMPLES + 40; i++) send(24'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_ovf",   int'(bus.overflow),  0);
        check("post_rst_valid", int'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        h0 = hs_count;
        for (int i = 0; i < BLK_SAMPLES; i++) send(24'($urandom));
        drain("fresh");
        check("fresh_count", hs_count - h0, BLK_SAMPLES);

        check("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ycbcr_block_buffer.md
Name: ycbcr_block_buffer

Overview:
- Downstream neighbour of the RGB-to-YCbCr converter.
- Captures the converter's packed {Cr,Cb,Y} pixel stream into 8x8 blocks using a two-bank ping-pong buffer.
- Level-shifts each component to signed (x-128) and replays each completed block as three parallel channel streams to the Y/Cb/Cr DCT stages, with valid/ready backpressure.
- The upstream stream has no backpressure, so input that arrives while no bank is free is dropped and flagged.

Parameters:
- PIX_W, 8, component width in bits. Input is 3*PIX_W; each output channel is PIX_W signed.
- BLK_LOG2, 6, log2 of samples per block (64). Must be even, because the block is square: side = 2**(BLK_LOG2/2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  input sample valid (the converter's enable_out)
- data_in  in  3*PIX_W  {Cr[23:16], Cb[15:8], Y[7:0]} unsigned
- y_out  out  PIX_W  signed Y-128
- cb_out  out  PIX_W  signed Cb-128
- cr_out  out  PIX_W  signed Cr-128
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts the sample when out_valid && out_ready
- out_first  out  1  qualifies sample index 0 of a block
- out_last  out  1  qualifies sample index 63 of a block
- overflow  out  1  sticky: an input sample was dropped

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0: y_out, cb_out, cr_out, out_valid, out_first, out_last, overflow.
  - Both bank-full flags cleared; wr_bank=0, rd_bank=0; wr_cnt=0, rd_cnt=0; read FSM to IDLE.
  - Storage contents are don't-care.
  - Reset asserted mid-block discards all partial and complete blocks; no output follows reset until 64 new samples have been written.
- Write side:
  - On enable: if full[wr_bank]==0, store data_in at mem[wr_bank][wr_cnt] and increment wr_cnt (6-bit).
  - The write at wr_cnt==63 sets full[wr_bank], toggles wr_bank and wraps wr_cnt to 0.
  - On enable with full[wr_bank]==1, the sample is dropped, overflow is set (stays set until rst) and wr_cnt holds.
  - A bank freed by the read side at edge E is writable from edge E+1 onward. An enable in cycle E still sees the bank as full and is dropped.
- Read FSM, states IDLE and STREAM:
  - IDLE: when full[rd_bank]==1, load the output register from mem[rd_bank][0], set out_valid=1 and out_first=1, set rd_cnt=1, go to STREAM.
  - STREAM, when out_valid && out_ready:
    - If the sample just accepted was index 63: clear full[rd_bank] and toggle rd_bank.
      - If the other bank is already full, load its index 0 in the same edge, stay in STREAM, and continue with no bubble.
      - Otherwise drop out_valid and go to IDLE.
    - Else load the next index and increment rd_cnt.
  - STREAM, when out_valid && !out_ready: y_out, cb_out, cr_out, out_first, out_last and out_valid hold stable.
  - out_last=1 exactly while index 63 is presented.
- Latency: the 64th enable sampled at edge N sets full at N. With the read side idle, out_valid is high from edge N+1.
  - Sustained throughput is 1 sample/clk when out_ready is held at 1.
  - A continuous 64-sample input burst never overflows if out_ready is held at 1.
- Arithmetic: each output is {~c[PIX_W-1], c[PIX_W-2:0]}, a two's-complement c-128 with no saturation.
  - 0 maps to -128, 128 to 0, 255 to +127.
- Read order (default): raster order, index 0..63, identical to write order.

Optional Feature:
- Macro YCC_BLK_TRANSPOSE_EN.
- Defined: the read address is the transpose of rd_cnt, i.e. {rd_cnt[2:0], rd_cnt[5:3]} (half-width swap in general). Blocks are emitted column-major for column-first DCTs.
  - out_first and out_last still mark the 1st and 64th emitted samples.
  - Index 0 and index 63 are unchanged by the transpose.
- Undefined: raster order, and the address swap logic is not compiled.

Decomposition:
- Shared package jpeg_enc_pkg holds:
  - PIX_W and BLK_LOG2 defaults
  - the BLK_SAMPLES constant
  - a packed ycc_pix_t typedef {cr, cb, y}
  - a level_shift function (MSB invert)
- One sub-module is natural: ycc_pingpong_ram. It holds the 2 x 64 x 24 register array and has one write port and one combinational read port; the bank select is the address MSB.
- FSM, counters and full flags stay in the top level.

Test Plan:
- 64 enables with Y=i, Cb=255-i, Cr=128, out_ready=1 -> out_valid rises 1 clk after the last enable. y_out runs -128..-65, cb_out runs 127..64, cr_out=0 throughout. out_first on sample 0, out_last on sample 63, overflow=0.
- 128 back-to-back enables, out_ready=1 -> 128 consecutive valid outputs with no bubble between blocks, overflow=0.
- Fill both banks with out_ready=0, then 1 more enable -> that sample is dropped and overflow=1. Release out_ready -> exactly 128 samples emerge, in order, with stable data during the stall.
- Toggle out_ready randomly during a block -> y_out, cb_out, cr_out and out_* hold while out_ready=0; no sample is lost or duplicated.
- Assert rst after 40 samples of a block, then send 64 fresh samples -> only the fresh block is output, and overflow is cleared.
- With YCC_BLK_TRANSPOSE_EN defined and Y=i -> the output Y sequence is 0,8,16,...,56,1,9,...,63, each minus 128.
